// File: rtl/mk_operand_feeder_if.sv
// Handshake bundle between the operand feeder and its environment: enqueue
// side, start/result/check method side, and status counters.
interface mk_operand_feeder_if #(
  parameter int WIDTH = 9
);
  logic [WIDTH-1:0] enq_a;
  logic [WIDTH-1:0] enq_b;
  logic             EN_enq;
  logic             RDY_enq;

  logic [WIDTH-1:0] start_st_a;
  logic [WIDTH-1:0] start_st_b;
  logic             EN_start;
  logic             RDY_start;

  logic [WIDTH-1:0] result_st_c;
  logic [WIDTH-1:0] result;
  logic             RDY_result;

  logic [WIDTH-1:0] check_st_d;
  logic             EN_check;
  logic             RDY_check;
  logic [WIDTH-1:0] check;

  logic [WIDTH-1:0] last_check;
  logic [7:0]       issued_count;
  logic [7:0]       done_count;

  // Feeder side
  modport master (
    input  enq_a, enq_b, EN_enq, RDY_start, result, RDY_result, RDY_check, check,
    output RDY_enq, start_st_a, start_st_b, EN_start, result_st_c,
           check_st_d, EN_check, last_check, issued_count, done_count
  );

  // Environment side
  modport slave (
    output enq_a, enq_b, EN_enq, RDY_start, result, RDY_result, RDY_check, check,
    input  RDY_enq, start_st_a, start_st_b, EN_start, result_st_c,
           check_st_d, EN_check, last_check, issued_count, done_count
  );
endinterface

// File: rtl/mk_operand_feeder.sv
// Operand feeder: buffers (A,B) operand pairs in a small FIFO and drives one
// start -> result -> check transaction at a time against a method-style DUT.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ISSUE    | idle / waiting for a queued operand pair and RDY_start
// WAIT_RES | start fired, waiting for RDY_result to capture the result
// CHECK    | result captured, waiting for RDY_check to fire check
module mk_operand_feeder #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input logic               CLK,
  input logic               RST_N,
  mk_operand_feeder_if.master bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ISSUE    = 2'd0,
    WAIT_RES = 2'd1,
    CHECK    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] result_st_c_q, result_st_c_d;
  logic [WIDTH-1:0] check_st_d_q, check_st_d_d;
  logic [WIDTH-1:0] last_check_q, last_check_d;
  logic [7:0]       issued_q, issued_d;
  logic [7:0]       done_q, done_d;

  logic             rdy_enq;
  logic             fifo_nempty;
  logic             enq_fire;
  logic             en_start;
  logic             en_check;
  logic             res_take;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;

  // Readiness depends on registered occupancy only, and is held low in reset
  assign rdy_enq     = RST_N && (count_q < CW'(DEPTH));
  assign fifo_nempty = (count_q != '0);
  assign enq_fire    = bus.EN_enq && rdy_enq;
  assign head_a      = fifo_nempty ? mem_a_q[rd_ptr_q] : '0;
  assign head_b      = fifo_nempty ? mem_b_q[rd_ptr_q] : '0;
  assign res_take    = (state_q == WAIT_RES) && bus.RDY_result;

  // FIFO storage write; entries need no reset since the head is gated by occupancy
  always_ff @(posedge CLK) begin
    if (enq_fire) begin
      mem_a_q[wr_ptr_q] <= bus.enq_a;
      mem_b_q[wr_ptr_q] <= bus.enq_b;
    end
  end

  // FIFO pointer/occupancy next-state; simultaneous push and pop leaves occupancy unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (en_start) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({enq_fire, en_start})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= ISSUE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ISSUE:    if (en_start)       state_d = WAIT_RES;
      WAIT_RES: if (bus.RDY_result) state_d = CHECK;
      CHECK:    if (en_check)       state_d = ISSUE;
      default:                      state_d = ISSUE;
    endcase
  end

  // FSM outputs: method strobes, both forced low while in reset
  always_comb begin
    en_start = 1'b0;
    en_check = 1'b0;
    case (state_q)
      ISSUE:   en_start = RST_N && fifo_nempty && bus.RDY_start;
      CHECK:   en_check = RST_N && bus.RDY_check;
      default: ;
    endcase
  end

  // Datapath next-state: argument latches, last check value, wrapping counters
  always_comb begin
    result_st_c_d = en_start ? head_a : result_st_c_q;
    check_st_d_d  = res_take ? bus.result : check_st_d_q;
    last_check_d  = en_check ? bus.check : last_check_q;
    issued_d      = issued_q + {7'd0, en_start};
    done_d        = done_q + {7'd0, en_check};
  end

  // FIFO control and datapath registers; reset discards any in-flight transaction
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      result_st_c_q <= '0;
      check_st_d_q  <= '0;
      last_check_q  <= '0;
      issued_q      <= '0;
      done_q        <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      result_st_c_q <= result_st_c_d;
      check_st_d_q  <= check_st_d_d;
      last_check_q  <= last_check_d;
      issued_q      <= issued_d;
      done_q        <= done_d;
    end
  end

  assign bus.RDY_enq      = rdy_enq;
  assign bus.start_st_a   = head_a;
  assign bus.start_st_b   = head_b;
  assign bus.EN_start     = en_start;
  assign bus.EN_check     = en_check;
  assign bus.result_st_c  = result_st_c_q;
  assign bus.check_st_d   = check_st_d_q;
  assign bus.last_check   = last_check_q;
  assign bus.issued_count = issued_q;
  assign bus.done_count   = done_q;

endmodule

// File: tb/tb_mk_operand_feeder.sv
// Directed bench for mk_operand_feeder with an operand scoreboard and a
// downstream model that returns result = A+B and echoes it as the check value.
module tb_mk_operand_feeder;

  logic CLK;
  logic RST_N;

  mk_operand_feeder_if #(.WIDTH(9)) bus ();

  mk_operand_feeder #(.WIDTH(9), .DEPTH(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] sb_a [$];
  logic [8:0] sb_b [$];
  logic [8:0] inflight_a   = '0;
  logic [8:0] inflight_sum = '0;
  logic       inflight_v   = 1'b0;
  logic [7:0] issued_model = '0;
  int         done_model   = 0;
  logic [8:0] exp_last     = '0;
  logic       last_pending = 1'b0;
  int         cyc = 0;
  int         st_cyc = 0;
  int         chk_cyc = 0;

  assign bus.result = inflight_sum;
  assign bus.check  = inflight_sum;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: scoreboard pop on start, transaction check on check fire
  always @(negedge CLK) begin
    cyc++;
    if (RST_N) begin
      if (last_pending) begin
        chk("last_check", 32'(bus.last_check), 32'(exp_last));
        chk("done_count", 32'(bus.done_count), 32'(done_model[7:0]));
        last_pending = 1'b0;
      end
      chk("start_check_excl", 32'(bus.EN_start & bus.EN_check), 32'd0);
      if (bus.EN_start === 1'b1) begin
        if (sb_a.size() == 0) begin
          chk("unexpected_start", 32'd1, 32'd0);
        end else begin
          logic [8:0] ea, eb;
          ea = sb_a.pop_front();
          eb = sb_b.pop_front();
          chk("start_st_a", 32'(bus.start_st_a), 32'(ea));
          chk("start_st_b", 32'(bus.start_st_b), 32'(eb));
          inflight_a   = ea;
          inflight_sum = 9'(ea + eb);
          inflight_v   = 1'b1;
          issued_model = issued_model + 8'd1;
          st_cyc       = cyc;
        end
      end
      if (bus.EN_check === 1'b1) begin
        if (!inflight_v) begin
          chk("unexpected_check", 32'd1, 32'd0);
        end else begin
          chk("result_st_c", 32'(bus.result_st_c), 32'(inflight_a));
          chk("check_st_d", 32'(bus.check_st_d), 32'(inflight_sum));
          chk("issued_count", 32'(bus.issued_count), 32'(issued_model));
          done_model++;
          exp_last     = inflight_sum;
          last_pending = 1'b1;
          inflight_v   = 1'b0;
          chk_cyc      = cyc;
        end
      end
    end
  end

  task automatic clear_model();
    sb_a.delete();
    sb_b.delete();
    inflight_v   = 1'b0;
    issued_model = '0;
    done_model   = 0;
    last_pending = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    clear_model();
    @(negedge CLK); #1;
    chk("rst_rdy_enq", 32'(bus.RDY_enq), 32'd0);
    chk("rst_en_start", 32'(bus.EN_start), 32'd0);
    chk("rst_en_check", 32'(bus.EN_check), 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK); #1;
    chk("rst_issued", 32'(bus.issued_count), 32'd0);
    chk("rst_done", 32'(bus.done_count), 32'd0);
    chk("rst_last_check", 32'(bus.last_check), 32'd0);
    chk("rst_result_st_c", 32'(bus.result_st_c), 32'd0);
    chk("rst_check_st_d", 32'(bus.check_st_d), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
  endtask

  // One-cycle enqueue attempt; starts and ends just after a rising edge
  task automatic enq(input logic [8:0] a, input logic [8:0] b, input logic exp_acc);
    bus.enq_a  = a;
    bus.enq_b  = b;
    bus.EN_enq = 1'b1;
    @(negedge CLK); #1;
    chk("rdy_enq", 32'(bus.RDY_enq), 32'(exp_acc));
    if (exp_acc) begin
      sb_a.push_back(a);
      sb_b.push_back(b);
    end
    @(posedge CLK); #1;
    bus.EN_enq = 1'b0;
  endtask

  // Enqueue that holds EN_enq until the FIFO has room (bounded)
  task automatic enq_block(input logic [8:0] a, input logic [8:0] b);
    bit ok;
    ok = 1'b0;
    bus.enq_a  = a;
    bus.enq_b  = b;
    bus.EN_enq = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK); #1;
      if (bus.RDY_enq) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
    if (ok) begin
      sb_a.push_back(a);
      sb_b.push_back(b);
      @(posedge CLK); #1;
    end else begin
      chk("enq_timeout", 32'd1, 32'd0);
    end
    bus.EN_enq = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (done_model >= target) break;
      @(negedge CLK); #1;
    end
    chk(tag, 32'(done_model), 32'(target));
  endtask

  task automatic wait_start(input logic [7:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (issued_model == target) break;
      @(negedge CLK); #1;
    end
    chk("wait_start", 32'(issued_model), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N          = 1'b0;
    bus.enq_a      = '0;
    bus.enq_b      = '0;
    bus.EN_enq     = 1'b0;
    bus.RDY_start  = 1'b1;
    bus.RDY_result = 1'b1;
    bus.RDY_check  = 1'b1;

    // Enqueue attempted during reset must be ignored
    bus.enq_a  = 9'd11;
    bus.enq_b  = 9'd22;
    bus.EN_enq = 1'b1;
    do_reset();
    bus.EN_enq = 1'b0;
    @(negedge CLK); #1;
    chk("no_start_after_rst", 32'(bus.EN_start), 32'd0);
    @(negedge CLK); #1;
    chk("no_start_after_rst2", 32'(bus.EN_start), 32'd0);

    // Basic transaction, enqueued in the first cycle out of reset
    do_reset();
    enq(9'd3, 9'd5, 1'b1);
    wait_done(1, 20, "basic_done");
    @(negedge CLK); #1;
    chk("basic_latency", 32'(chk_cyc - st_cyc), 32'd2);
    chk("basic_result_st_c", 32'(bus.result_st_c), 32'd3);
    chk("basic_check_st_d", 32'(bus.check_st_d), 32'd8);
    chk("basic_last_check", 32'(bus.last_check), 32'd8);
    chk("basic_issued", 32'(bus.issued_count), 32'd1);
    chk("basic_done", 32'(bus.done_count), 32'd1);

    // Fill to full with start blocked, overflow dropped, then drain in order
    do_reset();
    bus.RDY_start = 1'b0;
    enq(9'd101, 9'd1, 1'b1);
    enq(9'd102, 9'd2, 1'b1);
    enq(9'd103, 9'd3, 1'b1);
    enq(9'd104, 9'd4, 1'b1);
    chk("full_no_start", 32'(bus.EN_start), 32'd0);
    enq(9'd105, 9'd5, 1'b0);
    bus.RDY_start = 1'b1;
    wait_done(4, 40, "full_drain_done");
    repeat (3) begin
      @(negedge CLK); #1;
      chk("full_idle_start", 32'(bus.EN_start), 32'd0);
    end
    chk("full_issued", 32'(bus.issued_count), 32'd4);
    chk("full_done", 32'(bus.done_count), 32'd4);

    // Result stall: no strobes while waiting, completion one cycle after release
    do_reset();
    bus.RDY_result = 1'b0;
    enq(9'd20, 9'd30, 1'b1);
    wait_start(8'd1, 10);
    @(posedge CLK); #1;
    enq(9'd40, 9'd50, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      chk("stall_en_start", 32'(bus.EN_start), 32'd0);
      chk("stall_en_check", 32'(bus.EN_check), 32'd0);
      @(posedge CLK); #1;
    end
    bus.RDY_result = 1'b1;
    @(negedge CLK); #1;
    chk("stall_release_same", 32'(bus.EN_check), 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK); #1;
    chk("stall_release_next", 32'(bus.EN_check), 32'd1);
    wait_done(2, 20, "stall_done");

    // Occupancy 2 with enqueue concurrent to every start fire, across pointer wrap
    do_reset();
    bus.RDY_start = 1'b0;
    enq(9'd200, 9'd7, 1'b1);
    enq(9'd201, 9'd8, 1'b1);
    bus.RDY_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      enq(9'(300 + i), 9'(i * 3), 1'b1);
      @(negedge CLK); #1;
      chk("conc_issued", 32'(bus.issued_count), 32'(i + 1));
      @(posedge CLK); #1;
      @(posedge CLK); #1;
    end
    wait_done(8, 40, "conc_done");
    repeat (3) begin
      @(negedge CLK); #1;
      chk("conc_idle_start", 32'(bus.EN_start), 32'd0);
    end

    // Reset while in CHECK discards the transaction
    do_reset();
    bus.RDY_check = 1'b0;
    enq(9'd7, 9'd9, 1'b1);
    @(negedge CLK); #1;
    chk("rchk_start", 32'(bus.EN_start), 32'd1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(negedge CLK); #1;
    chk("rchk_held", 32'(bus.EN_check), 32'd0);
    chk("rchk_check_st_d", 32'(bus.check_st_d), 32'd16);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    bus.RDY_check = 1'b1;
    clear_model();
    @(negedge CLK); #1;
    chk("rchk_in_rst", 32'(bus.EN_check), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK); #1;
    chk("rchk_en_check", 32'(bus.EN_check), 32'd0);
    chk("rchk_en_start", 32'(bus.EN_start), 32'd0);
    chk("rchk_done", 32'(bus.done_count), 32'd0);
    chk("rchk_issued", 32'(bus.issued_count), 32'd0);
    chk("rchk_result_st_c", 32'(bus.result_st_c), 32'd0);
    chk("rchk_check_st_d", 32'(bus.check_st_d), 32'd0);
    chk("rchk_last_check", 32'(bus.last_check), 32'd0);
    chk("rchk_start_st_a", 32'(bus.start_st_a), 32'd0);
    repeat (3) begin
      @(negedge CLK); #1;
      chk("rchk_no_check", 32'(bus.EN_check), 32'd0);
    end

    // 257 transactions: both counters wrap to 1
    do_reset();
    for (int i = 0; i < 257; i++) begin
      enq_block(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
    end
    wait_done(257, 100, "wrap_done");
    @(negedge CLK); #1;
    chk("wrap_issued", 32'(bus.issued_count), 32'd1);
    chk("wrap_done_count", 32'(bus.done_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mk_operand_feeder.md
MK_OPERAND_FEEDER -- requirements
Module: mk_operand_feeder

Interface
REQ-001 Parameter WIDTH, default 9: operand/result bit width.
REQ-002 Parameter DEPTH, default 4: operand FIFO entries, power of two, at least 2.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, synchronous, active-low.
REQ-005 enq_a  input  WIDTH  operand A to enqueue.
REQ-006 enq_b  input  WIDTH  operand B to enqueue.
REQ-007 EN_enq  input  1  enqueue strobe; honoured only when RDY_enq=1.
REQ-008 RDY_enq  output  1  FIFO not full.
REQ-009 start_st_a  output  WIDTH  FIFO head operand A to design under test.
REQ-010 start_st_b  output  WIDTH  FIFO head operand B.
REQ-011 EN_start  output  1  start-method fire strobe.
REQ-012 RDY_start  input  1  downstream start ready.
REQ-013 result_st_c  output  WIDTH  argument of result method = operand A of in-flight transaction.
REQ-014 result  input  WIDTH  result method return value.
REQ-015 RDY_result  input  1  result valid.
REQ-016 check_st_d  output  WIDTH  check argument = latched result.
REQ-017 EN_check  output  1  check-method fire strobe.
REQ-018 RDY_check  input  1  downstream check ready.
REQ-019 check  input  WIDTH  check method return value.
REQ-020 last_check  output  WIDTH  most recent check return value.
REQ-021 issued_count  output  8  number of start fires, modulo 256.
REQ-022 done_count  output  8  number of check fires, modulo 256.

Function
REQ-023 FIFO: enqueue when EN_enq=1 and RDY_enq=1; RDY_enq=(occupancy<DEPTH), derived from registered occupancy only.
REQ-024 EN_enq while RDY_enq=0 is ignored; no state change, no data overwrite.
REQ-025 Simultaneous enqueue and dequeue: occupancy unchanged, both take effect; pointers wrap modulo DEPTH.
REQ-026 FSM states ISSUE, WAIT_RES, CHECK; one transaction in flight at most.
REQ-027 ISSUE: EN_start = (occupancy>0) and RDY_start, combinational; start_st_a/b show FIFO head (0 when empty).
REQ-028 On start fire: dequeue head, latch head A into result_st_c register, increment issued_count, go WAIT_RES next cycle.
REQ-029 WAIT_RES: EN_start=0, EN_check=0; when RDY_result=1, latch result into check_st_d register, go CHECK.
REQ-030 CHECK: EN_check = RDY_check; on fire latch check into last_check, increment done_count, return to ISSUE.
REQ-031 Minimum cycles per transaction = 3 (start, result sample, check); no stall cycles beyond those caused by ready inputs.
REQ-032 Counters wrap 255 -> 0 without flag.
REQ-033 EN_start and EN_check never asserted in the same cycle.

Reset
REQ-034 RST_N=0 at a clock edge: FIFO emptied, state ISSUE, counters 0, result_st_c/check_st_d/last_check 0; in-flight transaction discarded.
REQ-035 While RST_N=0: EN_start=0, EN_check=0, RDY_enq=0; enqueues ignored.
REQ-036 First enqueue accepted in the first cycle with RST_N=1.

Verification
REQ-037 Enqueue (3,5), RDY_start=RDY_result=RDY_check=1, result=8, check=8 -> EN_start 1 cycle with a=3,b=5; result_st_c=3; check_st_d=8; last_check=8; issued_count=done_count=1.
REQ-038 RDY_start=0, enqueue 4 pairs then a 5th -> RDY_enq=0 after 4th, 5th dropped; release RDY_start -> exactly 4 transactions, in order, issued_count=4.
REQ-039 RDY_result held 0 for 10 cycles in WAIT_RES -> no EN_start/EN_check during hold; completes 1 cycle after RDY_result=1.
REQ-040 FIFO at occupancy 2, enqueue concurrent with start fire -> occupancy stays 2, data order preserved across pointer wrap.
REQ-041 Assert RST_N=0 in CHECK state -> next cycle all outputs 0, state ISSUE, done_count unchanged at 0, transaction not completed.
REQ-042 Run 257 transactions -> issued_count=done_count=1.
